// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;
    localparam int ITER     = MD_WIDTH;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) producing HI/LO.
// Multiply is shift-add on a 64-bit accumulator, divide is restoring
// shift-subtract; signed operations run on magnitudes and fix signs at the end.
// Optional feature macro: DIVZERO_TRAP_EN (divide by zero finishes one edge
// after accept with div_zero raised and HI/LO untouched).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    md_op_e           r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_hi;
    logic             r_neg_lo;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;

    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_trap;
    logic             w_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // A divide by zero only short-circuits the iteration when the trap is built in.
`ifdef DIVZERO_TRAP_EN
    assign w_trap = op[1] & (b == {WIDTH{1'b0}});
`else
    assign w_trap = 1'b0;
`endif

    // Signed ops iterate on magnitudes; the operand signs are remembered for FIX.
    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & a[WIDTH-1];
    assign w_sign_b = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (-a) : a;
    assign w_mag_b  = w_sign_b ? (-b) : b;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a trapped divide skips RUN and goes straight to FIX.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_trap ? FIX : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: busy while heading anywhere but IDLE, done on leaving FIX.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt != IDLE) begin
            w_busy_nxt = 1'b1;
        end else begin
            w_busy_nxt = 1'b0;
        end
        if (r_state == FIX) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    // One iteration step of either the shift-add multiply or restoring divide.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, r_opnd};
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_step_hi   = r_acc_hi;
        w_step_lo   = r_acc_lo;
        if (r_op[1]) begin
            if (w_div_shift >= {1'b0, r_opnd}) begin
                w_step_hi = w_div_diff[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc_lo[0]) begin
                w_step_hi = w_mul_sum[WIDTH:1];
                w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
            end else begin
                w_step_hi = {1'b0, r_acc_hi[WIDTH-1:1]};
                w_step_lo = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Sign correction: full 64-bit negate for products, per-half for quotient/remainder.
    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_fix_hi = r_acc_hi;
        w_fix_lo = r_acc_lo;
        if (r_op[1]) begin
            w_fix_hi = r_neg_hi ? (-r_acc_hi) : r_acc_hi;
            w_fix_lo = r_neg_lo ? (-r_acc_lo) : r_acc_lo;
        end else begin
            if (r_neg_lo) begin
                w_prod = -{r_acc_hi, r_acc_lo};
            end else begin
                w_prod = {r_acc_hi, r_acc_lo};
            end
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Shared accumulator datapath: load at accept, iterate in RUN, publish in FIX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op     <= MULT;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= {WIDTH{1'b0}};
            r_opnd   <= {WIDTH{1'b0}};
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= md_op_e'(op);
                        r_cnt    <= {CNT_W{1'b0}};
                        r_acc_hi <= {WIDTH{1'b0}};
                        r_acc_lo <= op[1] ? w_mag_a : w_mag_b;
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_neg_lo <= w_sign_a ^ w_sign_b;
                        r_neg_hi <= op[1] ? w_sign_a : (w_sign_a ^ w_sign_b);
                        r_dz     <= w_trap;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    if (!r_dz) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

`ifdef DIVZERO_TRAP_EN
    logic r_div_zero;

    // Divide-by-zero flag pulses alongside done for a trapped divide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= (r_state == FIX) & r_dz;
        end
    end

    assign div_zero = r_div_zero;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit; expectations follow DIVZERO_TRAP_EN if defined.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int errors = 0;
    int checks = 0;
    int n;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic accept(input logic [1:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, input bit hold);
        @(negedge clock);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        int i;
        cnt = 0;
        i   = 0;
        while (i < 100 && cnt == 0) begin
            @(posedge clock);
            #1;
            i++;
            if (done) cnt = i;
        end
        if (cnt == 0) cnt = -1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        reset = 1'b1;
    endtask

    task automatic test_mult;
        accept(2'b00, 32'h7, 32'hFFFF_FFFD, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b want 1", busy); end
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", n); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b want 0", busy); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end

        accept(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", n); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end

        accept(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(n);
        checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo: got %h want 0", lo); end
    endtask

    task automatic test_div;
        accept(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0);
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", n); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end

        accept(2'b11, 32'hFFFF_FFF9, 32'h2, 1'b0);
        wait_done(n);
        checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL divu_hi: got %h want 1", hi); end

        accept(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_div_zero;
        accept(2'b10, 32'h5, 32'h0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy: got %b want 1", busy); end
        wait_done(n);
`ifdef DIVZERO_TRAP_EN
        checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", n); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL dz_lo_kept: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL dz_hi_kept: got %h want 0", hi); end
        @(posedge clock); #1;
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse: got %b want 0", div_zero); end
`else
        checks++; if (n !== 33) begin errors++; $display("FAIL dz_latency: got %0d want 33", n); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag: got %b want 0", div_zero); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h5) begin errors++; $display("FAIL dz_hi: got %h want 5", hi); end
`endif
    endtask

    task automatic test_busy_start;
        int cnt;
        accept(2'b00, 32'h3, 32'h5, 1'b0);
        cnt = 0;
        while (cnt < 100 && !done) begin
            @(negedge clock);
            start = (cnt == 4);
            op    = 2'b10;
            a     = 32'd100;
            b     = 32'd7;
            @(posedge clock);
            #1;
            cnt++;
        end
        start = 1'b0;
        checks++; if (cnt !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", cnt); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL busy_start_lo: got %h want f", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL busy_start_hi: got %h want 0", hi); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_noqueue: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        accept(2'b01, 32'd6, 32'd7, 1'b1);
        a = 32'd10;
        b = 32'd11;
        wait_done(n);
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %h want 2a", lo); end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", n); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
        start = 1'b0;
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", n); end
        checks++; if (lo !== 32'd110) begin errors++; $display("FAIL b2b_second_lo: got %h want 6e", lo); end
    endtask

    task automatic test_reset_mid;
        accept(2'b00, 32'd9, 32'd9, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        @(negedge clock);
        reset = 1'b1;
        accept(2'b00, 32'd3, 32'd4, 1'b0);
        wait_done(n);
        checks++; if (n !== 33) begin errors++; $display("FAIL rst_mid_latency: got %0d want 33", n); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL rst_mid_lo_after: got %h want c", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi_after: got %h want 0", hi); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_busy_start;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
